// File: rtl/result_deskew_collector_pkg.sv
// Shared systolic-array result types: lane count, element width and the result row.
package result_deskew_collector_pkg;

  localparam int unsigned SaLanes    = 8;
  localparam int unsigned SaAccWidth = 32;

  // One result row as seen by the array and write-back logic, element i is lane i.
  typedef logic [SaAccWidth-1:0] row_t [SaLanes];

  // Packed view of a row, convenient for storage and scoreboards.
  typedef logic [SaLanes-1:0][SaAccWidth-1:0] row_flat_t;

endpackage

// File: rtl/result_deskew_collector_sync_row_fifo.sv
// Show-ahead synchronous row FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is ignored and the caller flags the drop.
module result_deskew_collector_sync_row_fifo #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(Depth));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem_q[rd_ptr_q];

  // Row storage; not reset, the head is only meaningful while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/result_deskew_collector.sv
// Removes the diagonal skew of the systolic array result lanes and queues aligned rows
// for write-back. Define SKEW_CHECK_EN to check that all lane valids stay on the diagonal.
module result_deskew_collector
  import result_deskew_collector_pkg::*;
#(
  parameter int unsigned LANES      = SaLanes,
  parameter int unsigned ACC_WIDTH  = SaAccWidth,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LANES-1:0]     in_valid,
  input  logic [ACC_WIDTH-1:0] in_data [LANES],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data [LANES],
  output logic                 overflow,
  output logic                 skew_err,
  input  logic                 err_clr
);

`ifdef SKEW_CHECK_EN
  localparam bit SkewCheck = 1'b1;
`else
  localparam bit SkewCheck = 1'b0;
`endif

  localparam int unsigned RowW = LANES * ACC_WIDTH;

  logic [ACC_WIDTH-1:0] aligned_data [LANES];
  logic [LANES-1:0]     aligned_valid;
  logic [RowW-1:0]      push_row, head_row;
  logic                 fifo_full, fifo_empty, pop, drop;
  logic                 overflow_q, overflow_d;

  // Lane i is delayed by LANES-1-i stages so every lane lines up with the last one.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned Stages = LANES - 1 - i;
    if (Stages == 0) begin : g_direct
      assign aligned_data[i] = in_data[i];
      if (SkewCheck || i == 0) begin : g_valid
        assign aligned_valid[i] = in_valid[i];
      end else begin : g_no_valid
        assign aligned_valid[i] = 1'b0;
      end
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] data_q [Stages];

      // Data shift chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned s = 0; s < Stages; s++) data_q[s] <= '0;
        end else begin
          data_q[0] <= in_data[i];
          for (int unsigned s = 1; s < Stages; s++) data_q[s] <= data_q[s-1];
        end
      end
      assign aligned_data[i] = data_q[Stages-1];

      if (SkewCheck || i == 0) begin : g_valid
        logic [Stages-1:0] valid_q;

        // Valid shift chain, only lane 0 is needed unless skew checking is on.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid_q <= '0;
          end else begin
            valid_q[0] <= in_valid[i];
            for (int unsigned s = 1; s < Stages; s++) valid_q[s] <= valid_q[s-1];
          end
        end
        assign aligned_valid[i] = valid_q[Stages-1];
      end else begin : g_no_valid
        assign aligned_valid[i] = 1'b0;
      end
    end
  end

  // Flatten the aligned lanes into one FIFO word, lane i at slice i.
  always_comb begin
    push_row = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      push_row[i*ACC_WIDTH +: ACC_WIDTH] = aligned_data[i];
    end
  end

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign drop      = aligned_valid[0] & fifo_full & ~pop;

  result_deskew_collector_sync_row_fifo #(
    .Width (RowW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (aligned_valid[0]),
    .push_data (push_row),
    .pop       (pop),
    .head_data (head_row),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head row is forced to zero while nothing is queued.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      out_data[i] = out_valid ? head_row[i*ACC_WIDTH +: ACC_WIDTH] : '0;
    end
  end

  // A new drop wins over a same-cycle clear.
  assign overflow_d = (err_clr ? 1'b0 : overflow_q) | drop;
  assign overflow   = overflow_q;

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

`ifdef SKEW_CHECK_EN
  logic skew_err_q, skew_err_d, mismatch;

  assign mismatch   = (|aligned_valid) & ~(&aligned_valid);
  assign skew_err_d = (err_clr ? 1'b0 : skew_err_q) | mismatch;
  assign skew_err   = skew_err_q;

  // Sticky off-diagonal valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skew_err_q <= 1'b0;
    else        skew_err_q <= skew_err_d;
  end
`else
  logic unused_valid;

  assign unused_valid = ^{in_valid[LANES-1:1], aligned_valid[LANES-1:1]};
  assign skew_err     = 1'b0;
`endif

endmodule

// File: tb/tb_result_deskew_collector.sv
// Scoreboard bench for result_deskew_collector: rows are skewed onto the lanes by the
// driver, expected rows queued at injection and compared as the DUT hands them out.
module tb_result_deskew_collector;
  import result_deskew_collector_pkg::*;

  localparam int unsigned L = SaLanes;
  localparam int unsigned W = SaAccWidth;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [L-1:0] in_valid;
  logic [W-1:0] in_data [L];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data [L];
  logic         overflow;
  logic         skew_err;
  logic         err_clr;

  result_deskew_collector #(
    .LANES      (L),
    .ACC_WIDTH  (W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .skew_err  (skew_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

`ifdef SKEW_CHECK_EN
  localparam bit ExpSkew = 1'b1;
`else
  localparam bit ExpSkew = 1'b0;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  row_flat_t   exp_q [$];
  row_flat_t   exp_row;
  bit          pipe_v [L+1];
  row_flat_t   pipe_d [L+1];
  int          late_lane = -1;

  bit          lat_en = 1'b0;
  int unsigned lat_exp = 0;
  int unsigned valid_cycles = 0;
  int unsigned first_pop = 0;
  int unsigned last_pop = 0;
  bit          seen_pop = 1'b0;
  bit          prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic row_flat_t mk_row(input int unsigned base);
    row_flat_t r;
    for (int i = 0; i < L; i++) r[i] = W'(base + i);
    return r;
  endfunction

  // Shift the skew pipe by one cycle, start row r on lane 0 if v, and clock once.
  task automatic drive_cycle(input bit v, input row_flat_t r);
    for (int i = L; i >= 1; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = v;
    pipe_d[0] = r;
    for (int i = 0; i < L; i++) begin
      int src;
      src = (i == late_lane) ? i + 1 : i;
      in_valid[i] = pipe_v[src];
      in_data[i]  = pipe_v[src] ? pipe_d[src][i] : '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive_cycle(1'b0, '0);
  endtask

  task automatic clear_pipe();
    for (int i = 0; i <= L; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    in_valid = '0;
    for (int i = 0; i < L; i++) in_data[i] = '0;
  endtask

  // Edge counter.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        valid_cycles++;
        if (lat_en && !prev_valid) begin
          check_eq("latency", 64'(cyc), 64'(lat_exp));
          lat_en = 1'b0;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_row", 64'd1, 64'd0);
          end else begin
            exp_row = exp_q.pop_front();
            for (int i = 0; i < L; i++) begin
              check_eq($sformatf("row_lane%0d", i), 64'(out_data[i]), 64'(exp_row[i]));
            end
          end
          if (!seen_pop) first_pop = cyc;
          seen_pop = 1'b1;
          last_pop = cyc;
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    row_flat_t r;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    clear_pipe();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data0", 64'(out_data[0]), 64'd0);
    check_eq("rst_out_data7", 64'(out_data[L-1]), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_skew_err", 64'(skew_err), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Single row with latency.
    valid_cycles = 0;
    exp_q.push_back(mk_row(100));
    drive_cycle(1'b1, mk_row(100));
    lat_exp = cyc + 7;
    lat_en  = 1'b1;
    idle(12);
    check_eq("single_valid_cycles", 64'(valid_cycles), 64'd1);
    check_eq("single_latency_seen", 64'(lat_en), 64'd0);

    // Streaming six back-to-back rows.
    valid_cycles = 0;
    seen_pop     = 1'b0;
    for (int rr = 0; rr < 6; rr++) begin
      exp_q.push_back(mk_row(16 * rr));
      drive_cycle(1'b1, mk_row(16 * rr));
    end
    idle(12);
    check_eq("stream_valid_cycles", 64'(valid_cycles), 64'd6);
    check_eq("stream_consecutive", 64'(last_pop - first_pop), 64'd5);
    check_eq("stream_overflow", 64'(overflow), 64'd0);

    // Backpressure: fifth row dropped.
    out_ready = 1'b0;
    for (int rr = 0; rr < 5; rr++) begin
      if (rr < 4) exp_q.push_back(mk_row(1000 + 16 * rr));
      drive_cycle(1'b1, mk_row(1000 + 16 * rr));
    end
    idle(12);
    check_eq("bp_overflow_set", 64'(overflow), 64'd1);
    check_eq("bp_out_valid", 64'(out_valid), 64'd1);
    valid_cycles = 0;
    out_ready = 1'b1;
    idle(8);
    check_eq("bp_drained_rows", 64'(valid_cycles), 64'd4);
    check_eq("bp_empty", 64'(out_valid), 64'd0);
    check_eq("bp_overflow_sticky", 64'(overflow), 64'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check_eq("bp_overflow_clr", 64'(overflow), 64'd0);

    // Full FIFO with a pop on the cycle the fifth row lands.
    out_ready = 1'b0;
    for (int rr = 0; rr < 5; rr++) begin
      exp_q.push_back(mk_row(2000 + 16 * rr));
      drive_cycle(1'b1, mk_row(2000 + 16 * rr));
    end
    idle(6);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check_eq("fullpop_overflow", 64'(overflow), 64'd0);
    idle(3);
    check_eq("fullpop_overflow_late", 64'(overflow), 64'd0);
    valid_cycles = 0;
    out_ready = 1'b1;
    idle(8);
    check_eq("fullpop_rows", 64'(valid_cycles), 64'd4);
    check_eq("fullpop_sb", 64'(exp_q.size()), 64'd0);

    // Lane 3 valid one cycle late; row still written with lane 3 missing.
    late_lane = 3;
    r = mk_row(3000);
    r[3] = '0;
    exp_q.push_back(r);
    drive_cycle(1'b1, mk_row(3000));
    idle(12);
    check_eq("skew_err", 64'(skew_err), 64'(ExpSkew));
    late_lane = -1;
    idle(3);
    check_eq("skew_err_sticky", 64'(skew_err), 64'(ExpSkew));
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check_eq("skew_err_clr", 64'(skew_err), 64'd0);
    check_eq("skew_sb", 64'(exp_q.size()), 64'd0);

    // Reset while a row is half-way into the skew chains.
    drive_cycle(1'b1, mk_row(4000));
    idle(3);
    rst_n = 1'b0;
    clear_pipe();
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid_cycles = 0;
    idle(12);
    check_eq("midrst_no_row", 64'(valid_cycles), 64'd0);
    exp_q.push_back(mk_row(5000));
    drive_cycle(1'b1, mk_row(5000));
    idle(12);
    check_eq("midrst_next_row", 64'(valid_cycles), 64'd1);
    check_eq("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
